puf_challenge_sequencer: RTL and testbench

Control and measurement engine sitting directly downstream of the challenge LFSR in the RO PUF datapath. Seeds and steps the LFSR, applies each LFSR value as the ring-oscillator mux select and measures the selected oscillator pair over a fixed clock window. It then compares the two edge counts to form one response bit and packs RESP_BITS bits into a response word, which is released over a valid/ready handshake.

---
 rtl/puf_pkg.sv | 21 ++
 rtl/ro_edge_counter.sv | 42 ++++
 rtl/puf_challenge_sequencer.sv | 147 ++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and default constants for the RO PUF challenge sequencer.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        LOAD,
        SETTLE,
        MEASURE,
        COMPARE,
        STEP,
        DONE
    } state_t;

    localparam int unsigned DEF_CHAL_BITS     = 8;
    localparam int unsigned DEF_RESP_BITS     = 32;
    localparam int unsigned DEF_WIN_CYCLES    = 1024;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one ring-oscillator output, detects rising edges and
// counts them in a saturating counter with clear and enable.
module ro_edge_counter
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [2:0] sync;
    logic       rise;

    // sync[1:0] is the 2-flop synchroniser, sync[2] the edge reference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], ro};
        end
    end

    assign rise = sync[1] & ~sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && rise && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// RO PUF sequencer: steps the challenge LFSR, measures each selected
// oscillator pair over a fixed window and packs the response bits.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int unsigned CHAL_BITS     = DEF_CHAL_BITS,
    parameter int unsigned RESP_BITS     = DEF_RESP_BITS,
    parameter int unsigned WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAL_BITS-1:0] seed,
    output logic                 lfsr_en,
    output logic                 lfsr_seed_dv,
    output logic [CHAL_BITS-1:0] lfsr_seed,
    input  logic [CHAL_BITS-1:0] lfsr_data,
    output logic [CHAL_BITS-1:0] ro_sel,
    output logic                 ro_en,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp
);

    localparam int unsigned TMAX =
        (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW = $clog2(TMAX);
    localparam int unsigned IW =
        (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_WIN    = TW'(WIN_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE    = 1;
    localparam logic [IW-1:0] I_LAST   = IW'(RESP_BITS - 1);
    localparam logic [IW-1:0] I_ONE    = 1;

    state_t           state;
    state_t           state_nx;
    logic [TW-1:0]    tmr;
    logic             tmr_zero;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             cnt_clr;
    logic             cnt_en;

    assign tmr_zero = (tmr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SEED;
            SEED:    state_nx = LOAD;
            LOAD:    state_nx = SETTLE;
            SETTLE:  if (tmr_zero) state_nx = MEASURE;
            MEASURE: if (tmr_zero) state_nx = COMPARE;
            COMPARE: state_nx = STEP;
            STEP:    state_nx = (idx == I_LAST) ? DONE : LOAD;
            DONE:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lfsr_en      = 1'b0;
        lfsr_seed_dv = 1'b0;
        ro_en        = 1'b0;
        busy         = (state != IDLE);
        resp_valid   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        unique case (state)
            SEED: begin
                lfsr_en      = 1'b1;
                lfsr_seed_dv = 1'b1;
            end
            LOAD:    cnt_clr = 1'b1;
            SETTLE: begin
                ro_en   = 1'b1;
                cnt_clr = 1'b1;
            end
            MEASURE: begin
                ro_en  = 1'b1;
                cnt_en = 1'b1;
            end
            STEP:    lfsr_en = 1'b1;
            DONE:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_seed <= '0;
            ro_sel    <= '0;
            tmr       <= '0;
            idx       <= '0;
            resp      <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) lfsr_seed <= seed;
                SEED: idx <= '0;
                LOAD: begin
                    ro_sel <= lfsr_data;
                    tmr    <= T_SETTLE;
                end
                SETTLE: tmr <= tmr_zero ? T_WIN : tmr - T_ONE;
                MEASURE: if (!tmr_zero) tmr <= tmr - T_ONE;
                COMPARE: resp[idx] <= (cnt_a > cnt_b);
                STEP: if (idx != I_LAST) idx <= idx + I_ONE;
                default: ;
            endcase
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_a),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_b),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_b)
    );

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: instance 0 uses the common settings, instance 1 a
// 3-bit counter with a 64-cycle window so both counters can saturate.
module tb_puf_challenge_sequencer;

    typedef struct {
        int         k;
        logic [3:0] resp;
        int         t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start [2];
    logic       resp_ready [2];
    logic       lfsr_en [2];
    logic       lfsr_seed_dv [2];
    logic       ro_en [2];
    logic       ro_a [2] = '{1'b0, 1'b0};
    logic       ro_b [2] = '{1'b0, 1'b0};
    logic       busy [2];
    logic       resp_valid [2];
    logic [7:0] seed [2];
    logic [7:0] lfsr_seed [2];
    logic [7:0] ro_sel [2];
    logic [7:0] lq [2] = '{8'h00, 8'h00};
    logic [3:0] resp [2];
    logic [3:0] hold [2];

    int ha [2][256];
    int hb [2][256];
    int pa [2] = '{0, 0};
    int pb [2] = '{0, 0};
    int hs [5] = '{0, 1, 2, 4, 8};
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    exp_t       expq [$];
    logic [7:0] selq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    puf_challenge_sequencer #(
        .CHAL_BITS(8), .RESP_BITS(4), .WIN_CYCLES(16),
        .SETTLE_CYCLES(4), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .seed(seed[0]),
        .lfsr_en(lfsr_en[0]), .lfsr_seed_dv(lfsr_seed_dv[0]),
        .lfsr_seed(lfsr_seed[0]), .lfsr_data(lq[0]),
        .ro_sel(ro_sel[0]), .ro_en(ro_en[0]),
        .ro_a(ro_a[0]), .ro_b(ro_b[0]), .busy(busy[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp(resp[0])
    );

    puf_challenge_sequencer #(
        .CHAL_BITS(8), .RESP_BITS(4), .WIN_CYCLES(64),
        .SETTLE_CYCLES(4), .CNT_W(3)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .seed(seed[1]),
        .lfsr_en(lfsr_en[1]), .lfsr_seed_dv(lfsr_seed_dv[1]),
        .lfsr_seed(lfsr_seed[1]), .lfsr_data(lq[1]),
        .ro_sel(ro_sel[1]), .ro_en(ro_en[1]),
        .ro_a(ro_a[1]), .ro_b(ro_b[1]), .busy(busy[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp(resp[1])
    );

    function automatic logic [7:0] lfsr_next(logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Attached LFSR and oscillator array: half-period per challenge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (lfsr_en[k] === 1'b1)
                lq[k] <= lfsr_seed_dv[k] ? lfsr_seed[k]
                                         : lfsr_next(lq[k]);
            if (ro_en[k] !== 1'b1) begin
                ro_a[k] <= 1'b0;
                ro_b[k] <= 1'b0;
                pa[k]   <= 0;
                pb[k]   <= 0;
            end else begin
                if (ha[k][ro_sel[k]] != 0) begin
                    if (pa[k] >= ha[k][ro_sel[k]] - 1) begin
                        ro_a[k] <= ~ro_a[k];
                        pa[k]   <= 0;
                    end else pa[k] <= pa[k] + 1;
                end
                if (hb[k][ro_sel[k]] != 0) begin
                    if (pb[k] >= hb[k][ro_sel[k]] - 1) begin
                        ro_b[k] <= ~ro_b[k];
                        pb[k]   <= 0;
                    end else pb[k] <= pb[k] + 1;
                end
            end
        end
    end

    function automatic int per_bit(int k);
        return (k == 1) ? 64 + 4 + 3 : 16 + 4 + 3;
    endfunction

    // Edges seen in a window of a periodic wave, saturated at counter max
    function automatic int exp_cnt(int k, int h);
        int w;
        int mx;
        w  = (k == 1) ? 64 : 16;
        mx = (k == 1) ? 7 : 65535;
        if (h == 0) return 0;
        return (w / (2 * h) > mx) ? mx : w / (2 * h);
    endfunction

    task automatic fail(string name, int act, int req);
        miscompares++;
        vectors++;
        $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic chk(string name, int act, int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_run(int k, logic [7:0] s);
        logic [7:0] ch;
        logic [3:0] r;
        ch = s;
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            selq.push_back(ch);
            r[i] = exp_cnt(k, ha[k][ch]) > exp_cnt(k, hb[k][ch]);
            ch = lfsr_next(ch);
        end
        expq.push_back('{k: k, resp: r, t0: cyc});
    endtask

    // Monitor: pops expectations whenever a DUT presents an output
    initial begin
        logic pv [2];
        logic pe [2];
        logic hd [2];
        exp_t e;
        pv = '{1'b0, 1'b0};
        pe = '{1'b0, 1'b0};
        hd = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_n !== 1'b1) begin
                    pv[k] = 1'b0;
                    pe[k] = 1'b0;
                    hd[k] = 1'b0;
                    continue;
                end
                if (ro_en[k] && !pe[k]) begin
                    if (selq.size() == 0) fail("ro_sel_extra", ro_sel[k], 0);
                    else chk("ro_sel", ro_sel[k], selq.pop_front());
                end
                if (hd[k]) chk("idle_after_hs", {busy[k], resp_valid[k]}, 0);
                if (resp_valid[k] && !pv[k]) begin
                    if (expq.size() == 0) begin
                        fail("resp_extra", resp[k], 0);
                    end else begin
                        e = expq.pop_front();
                        chk("resp_inst", k, e.k);
                        chk("resp", resp[k], e.resp);
                        chk("latency", cyc - e.t0, 2 + 4 * per_bit(k));
                        hold[k] = e.resp;
                    end
                end else if (resp_valid[k]) begin
                    chk("resp_stable", resp[k], hold[k]);
                end
                hd[k] = resp_valid[k] && resp_ready[k];
                pv[k] = resp_valid[k];
                pe[k] = ro_en[k];
            end
        end
    end

    task automatic run(int k, logic [7:0] s, int bp, bit spur);
        int n;
        @(negedge clk);
        resp_ready[k] = (bp == 0);
        expect_run(k, s);
        start[k] = 1'b1;
        seed[k]  = s;
        @(negedge clk);
        start[k] = 1'b0;
        seed[k]  = 8'($urandom);
        if (spur) begin
            repeat (per_bit(k) + 4 + 6) @(negedge clk);
            chk("spur_in_measure", ro_en[k], 1);
            start[k] = 1'b1;
            seed[k]  = ~s;
            @(negedge clk);
            start[k] = 1'b0;
        end
        n = 0;
        while (resp_valid[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail("timeout_valid", n, 0);
        if (bp > 0) begin
            repeat (bp) @(negedge clk);
            resp_ready[k] = 1'b1;
            @(negedge clk);
            chk("idle_after_ready", {busy[k], resp_valid[k]}, 0);
        end
        n = 0;
        while (busy[k] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail("timeout_idle", n, 0);
        @(negedge clk);
    endtask

    task automatic fill(int k, int a, int b);
        for (int c = 0; c < 256; c++) begin
            ha[k][c] = a;
            hb[k][c] = b;
        end
    endtask

    task automatic fill_rand(int k);
        for (int c = 0; c < 256; c++) begin
            ha[k][c] = hs[$urandom_range(0, 4)];
            hb[k][c] = hs[$urandom_range(0, 4)];
        end
    endtask

    task automatic set_pat(int k, logic [7:0] s, logic [3:0] bits);
        logic [7:0] ch;
        ch = s;
        for (int i = 0; i < 4; i++) begin
            ha[k][ch] = bits[i] ? 2 : 4;
            hb[k][ch] = bits[i] ? 4 : 2;
            ch = lfsr_next(ch);
        end
    endtask

    initial begin
        logic [7:0] ch;
        for (int k = 0; k < 2; k++) begin
            start[k]      = 1'b0;
            seed[k]       = 8'h00;
            resp_ready[k] = 1'b1;
            fill(k, 0, 0);
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy[0], 0);
        chk("rst_valid", resp_valid[0], 0);
        chk("rst_resp", resp[0], 0);
        chk("rst_ctrl", {lfsr_en[0], lfsr_seed_dv[0], ro_en[0]}, 0);
        chk("rst_regs", {lfsr_seed[0], ro_sel[0]}, 0);

        fill(0, 2, 4);
        run(0, 8'h01, 0, 1'b0);
        fill(0, 4, 2);
        run(0, 8'h01, 0, 1'b0);
        fill(0, 2, 2);
        run(0, 8'h01, 0, 1'b0);
        set_pat(0, 8'h01, 4'b0101);
        run(0, 8'h01, 0, 1'b0);
        fill(0, 2, 4);
        run(0, 8'h01, 50, 1'b0);
        set_pat(0, 8'h01, 4'b0101);
        run(0, 8'h01, 0, 1'b1);

        // Abort in SETTLE of bit 2: no response is expected from it
        fill_rand(0);
        @(negedge clk);
        expect_run(0, 8'h3C);
        start[0] = 1'b1;
        seed[0]  = 8'h3C;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2 + 2 * per_bit(0) + 2 - 1) @(negedge clk);
        chk("pre_rst_settle", ro_en[0], 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl",
            {busy[0], resp_valid[0], lfsr_en[0], lfsr_seed_dv[0], ro_en[0]},
            0);
        chk("mid_rst_regs", {lfsr_seed[0], ro_sel[0], 4'h0, resp[0]}, 0);
        selq.delete();
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 8'hA5, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_rand(0);
            run(0, 8'($urandom_range(1, 255)), (r == 2) ? 7 : 0, 1'b0);
        end

        // Saturating instance: CNT_W=3, 64-cycle window
        ch = 8'h5A;
        ha[1][ch] = 1; hb[1][ch] = 2; ch = lfsr_next(ch);
        ha[1][ch] = 2; hb[1][ch] = 0; ch = lfsr_next(ch);
        ha[1][ch] = 8; hb[1][ch] = 1; ch = lfsr_next(ch);
        ha[1][ch] = 1; hb[1][ch] = 8;
        run(1, 8'h5A, 0, 1'b0);
        fill(1, 1, 2);
        run(1, 8'h33, 0, 1'b0);

        repeat (5) @(negedge clk);
        if (expq.size() != 0) fail("unconsumed_resp", expq.size(), 0);
        if (selq.size() != 0) fail("unconsumed_sel", selq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
